bp_egress_collector: RTL and testbench

- Egress-side counterpart of the BFT injection path: the tree has one wide input stream broadcast in at the root and N per-PE client streams coming out.
- This block drains the N per-PE streams (wdata/wvalid/wready/wlast) and merges them into one serialized stream for host or bench readback.
- Arbitration is packet-atomic round-robin, followed by a one-entry registered output stage.
- Sits beside the BFT top and is fed by the client-side m_axis_c_* streams.

---
 rtl/bp_egress_collector.sv | 107 ++++++++++
 tb/tb_bp_egress_collector.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_egress_collector.sv
// Egress collector: drains N per-PE flit streams into one serialized stream
// using packet-atomic round-robin and a one-entry registered output stage.
module bp_egress_collector #(
   parameter int N     = 32,
   parameter int D_W   = 32,
   parameter int A_W   = $clog2(N) + 1,
   parameter int W     = A_W + D_W + 1,
   parameter int LIMIT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [N*W-1:0]       s_axis_wdata,
   input  logic [N-1:0]         s_axis_wvalid,
   output logic [N-1:0]         s_axis_wready,
   input  logic [N-1:0]         s_axis_wlast,
   output logic [W-1:0]         m_axis_wdata,
   output logic                 m_axis_wvalid,
   input  logic                 m_axis_wready,
   output logic                 m_axis_wlast,
   output logic [$clog2(N)-1:0] m_axis_src,
   output logic [31:0]          pkt_cnt,
   output logic                 done
);

   localparam int S_W = $clog2(N);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t         state;
   logic [S_W-1:0] rr_ptr;
   logic [S_W-1:0] grant;
   logic [S_W-1:0] pick;
   logic [S_W-1:0] idx;
   logic           out_v;
   logic           any_v;
   logic           stream_rdy;
   logic           acc;
   logic           m_hs;
   logic [W-1:0]   sel_data;
   logic           sel_last;
   logic [31:0]    cnt_nxt;

   // Downward scan so the lowest offset from rr_ptr wins.
   always_comb begin
      pick = rr_ptr;
      idx  = rr_ptr;
      for (int k = N - 1; k >= 0; k--) begin
         idx = rr_ptr + S_W'(k);
         if (s_axis_wvalid[idx]) pick = idx;
      end
   end

   assign any_v    = |s_axis_wvalid;
   assign sel_data = s_axis_wdata[int'(grant)*W +: W];
   assign sel_last = s_axis_wlast[grant];

   assign stream_rdy = ce && (state == STREAM) && (!out_v || m_axis_wready);
   assign acc        = stream_rdy && s_axis_wvalid[grant];
   assign m_hs       = ce && out_v && m_axis_wready;

   assign s_axis_wready = stream_rdy ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
   assign m_axis_wvalid = out_v & ce;

   assign cnt_nxt = (m_hs && m_axis_wlast && (pkt_cnt != '1)) ? pkt_cnt + 32'd1
                                                                : pkt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant        <= '0;
         out_v        <= 1'b0;
         m_axis_wdata <= '0;
         m_axis_wlast <= 1'b0;
         m_axis_src   <= '0;
         pkt_cnt      <= '0;
         done         <= 1'b0;
      end else if (ce) begin
         if (m_hs) out_v <= 1'b0;
         if (acc) begin
            out_v        <= 1'b1;
            m_axis_wdata <= sel_data;
            m_axis_wlast <= sel_last;
            m_axis_src   <= grant;
         end
         pkt_cnt <= cnt_nxt;
         if (cnt_nxt >= 32'(LIMIT)) done <= 1'b1;
         unique case (state)
            IDLE: begin
               if (any_v) begin
                  grant <= pick;
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (acc && sel_last) begin
                  rr_ptr <= grant + S_W'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_egress_collector.sv
// Randomized, self-checking bench for bp_egress_collector
// (N=4, D_W=8, LIMIT=4) with a packet-level round-robin reference model.
module tb_bp_egress_collector;

   localparam int N     = 4;
   localparam int D_W   = 8;
   localparam int A_W   = 3;
   localparam int W     = A_W + D_W + 1;
   localparam int LIMIT = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ce  = 1'b1;
   logic [N*W-1:0] s_axis_wdata;
   logic [N-1:0]   s_axis_wvalid;
   logic [N-1:0]   s_axis_wready;
   logic [N-1:0]   s_axis_wlast;
   logic [W-1:0]   m_axis_wdata;
   logic           m_axis_wvalid;
   logic           m_axis_wready;
   logic           m_axis_wlast;
   logic [1:0]     m_axis_src;
   logic [31:0]    pkt_cnt;
   logic           done;

   bp_egress_collector #(
      .N(N), .D_W(D_W), .A_W(A_W), .W(W), .LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .s_axis_wdata(s_axis_wdata), .s_axis_wvalid(s_axis_wvalid),
      .s_axis_wready(s_axis_wready), .s_axis_wlast(s_axis_wlast),
      .m_axis_wdata(m_axis_wdata), .m_axis_wvalid(m_axis_wvalid),
      .m_axis_wready(m_axis_wready), .m_axis_wlast(m_axis_wlast),
      .m_axis_src(m_axis_src), .pkt_cnt(pkt_cnt), .done(done)
   );

   always #5 clk = ~clk;

   // Source flits stored as {last, data}.
   logic [W:0]   sq [N][$];
   logic [N-1:0] en;
   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int m_data[$], m_last[$], m_src[$], m_cyc[$], m_done[$];
   int a_src[$], a_cyc[$];

   task automatic clear_all();
      for (int i = 0; i < N; i++) sq[i].delete();
      m_data.delete(); m_last.delete(); m_src.delete();
      m_cyc.delete(); m_done.delete();
      a_src.delete(); a_cyc.delete();
   endtask

   task automatic drive();
      logic [W:0] f;
      for (int i = 0; i < N; i++) begin
         if (en[i] && sq[i].size() > 0) begin
            f = sq[i][0];
            s_axis_wvalid[i]         = 1'b1;
            s_axis_wdata[i*W +: W]   = f[W-1:0];
            s_axis_wlast[i]          = f[W];
         end else begin
            s_axis_wvalid[i]         = 1'b0;
            s_axis_wdata[i*W +: W]   = '0;
            s_axis_wlast[i]          = 1'b0;
         end
      end
   endtask

   task automatic add_pkt(input int s, input int len, input int base);
      for (int j = 0; j < len; j++)
         sq[s].push_back({(j == len - 1), W'(base + j)});
   endtask

   task automatic step();
      logic [N-1:0] hs;
      @(negedge clk);
      cyc++;
      hs = s_axis_wvalid & s_axis_wready;
      for (int i = 0; i < N; i++)
         if (hs[i]) begin a_src.push_back(i); a_cyc.push_back(cyc); end
      if (m_axis_wvalid && m_axis_wready) begin
         m_data.push_back(int'(m_axis_wdata));
         m_last.push_back(int'(m_axis_wlast));
         m_src.push_back(int'(m_axis_src));
         m_cyc.push_back(cyc);
         m_done.push_back(int'(done));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (hs[i]) void'(sq[i].pop_front());
      drive();
   endtask

   task automatic run_until(input int n, input int budget, output bit ok);
      int b;
      b = budget;
      while (m_data.size() < n && b > 0) begin step(); b--; end
      ok = (m_data.size() >= n);
   endtask

   task automatic acc_until(input int n, input int budget, output bit ok);
      int b;
      b = budget;
      while (a_src.size() < n && b > 0) begin step(); b--; end
      ok = (a_src.size() >= n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_all();
      en = '0;
      ce = 1'b1;
      m_axis_wready = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) add_pkt(i, 1, 'h080 + i);
      en = '1;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (s_axis_wready !== '0 || m_axis_wvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready wready=%b mvalid=%b need 0", s_axis_wready, m_axis_wvalid);
         end
         checks++;
         if (pkt_cnt !== 32'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt pkt_cnt=%0d done=%b need 0/0", pkt_cnt, done);
         end
      end
      rst = 1'b0;
      run_until(1, 20, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL reset_timeout got %0d flits need 1", m_data.size());
      end else if (m_src[0] !== 0) begin
         fails++;
         $display("FAIL reset_first_grant src=%0d need 0", m_src[0]);
      end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      add_pkt(2, 3, 'h010);
      en = 4'b0100;
      drive();
      run_until(3, 30, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL single_timeout got %0d flits need 3", m_data.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (m_data[j] !== 'h010 + j || m_src[j] !== 2 || m_last[j] !== int'(j == 2)) begin
               fails++;
               $display("FAIL single_flit%0d data=%h src=%0d last=%0d need %h/2/%0d",
                        j, m_data[j], m_src[j], m_last[j], 'h010 + j, int'(j == 2));
            end
            checks++;
            if (m_cyc[j] !== a_cyc[j] + 1 || m_cyc[j] !== m_cyc[0] + j) begin
               fails++;
               $display("FAIL single_latency%0d mcyc=%0d acyc=%0d need acyc+1 consecutive",
                        j, m_cyc[j], a_cyc[j]);
            end
         end
      end
      checks++;
      if (pkt_cnt !== 32'd1) begin
         fails++;
         $display("FAIL single_pkt_cnt got %0d need 1", pkt_cnt);
      end
   endtask

   task automatic test_rr();
      bit ok;
      int exp_src[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) add_pkt(i, 1, 'h100 + p * 16 + i);
      en = '1;
      drive();
      run_until(5, 40, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL rr_timeout got %0d flits need 5", m_data.size());
      end else begin
         for (int j = 0; j < 5; j++) begin
            checks++;
            if (m_src[j] !== exp_src[j] || m_done[j] !== int'(j == 4)) begin
               fails++;
               $display("FAIL rr_order%0d src=%0d done=%0d need %0d/%0d",
                        j, m_src[j], m_done[j], exp_src[j], int'(j == 4));
            end
         end
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (a_cyc[j+1] - a_cyc[j] !== 2) begin
               fails++;
               $display("FAIL rr_gap%0d got %0d cycles need 2", j, a_cyc[j+1] - a_cyc[j]);
            end
         end
      end
      checks++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL rr_done got %b need 1", done);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n0;
      logic [W-1:0] hold;
      do_reset();
      add_pkt(1, 4, 'h200);
      en = 4'b0010;
      drive();
      acc_until(1, 20, ok);
      m_axis_wready = 1'b0;
      n0 = a_src.size();
      hold = m_axis_wdata;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (s_axis_wready[1] !== 1'b0 || m_axis_wvalid !== 1'b1 || m_axis_wdata !== hold) begin
            fails++;
            $display("FAIL bp_stall%0d wready1=%b mvalid=%b data=%h need 0/1/%h",
                     k, s_axis_wready[1], m_axis_wvalid, m_axis_wdata, hold);
         end
      end
      checks++;
      if (a_src.size() - n0 > 1 || m_data.size() !== 0) begin
         fails++;
         $display("FAIL bp_accepts got %0d accepts %0d out need <=1/0",
                  a_src.size() - n0, m_data.size());
      end
      m_axis_wready = 1'b1;
      run_until(4, 30, ok);
      repeat (4) step();
      checks++;
      if (m_data.size() !== 4) begin
         fails++;
         $display("FAIL bp_count got %0d flits need 4", m_data.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (m_data[j] !== 'h200 + j || m_src[j] !== 1) begin
               fails++;
               $display("FAIL bp_flit%0d data=%h src=%0d need %h/1", j, m_data[j], m_src[j], 'h200 + j);
            end
         end
      end
   endtask

   task automatic test_atomicity();
      bit ok;
      int exp_src[7] = '{3, 3, 3, 3, 0, 0, 1};
      do_reset();
      add_pkt(3, 4, 'h300);
      add_pkt(0, 2, 'h0a0);
      add_pkt(1, 1, 'h1b0);
      en = 4'b1000;
      drive();
      acc_until(1, 20, ok);
      en = 4'b1011;
      drive();
      run_until(7, 60, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL atom_timeout got %0d flits need 7", m_data.size());
      end else begin
         for (int j = 0; j < 7; j++) begin
            checks++;
            if (m_src[j] !== exp_src[j]) begin
               fails++;
               $display("FAIL atom_src%0d got %0d need %0d", j, m_src[j], exp_src[j]);
            end
         end
         checks++;
         if (m_data[3] !== 'h303 || m_last[3] !== 1) begin
            fails++;
            $display("FAIL atom_tail data=%h last=%0d need 303/1", m_data[3], m_last[3]);
         end
      end
   endtask

   task automatic test_ce_rst();
      bit ok;
      int nacc, nm;
      logic [W-1:0] hold;
      logic [31:0] hold_cnt;
      do_reset();
      add_pkt(1, 1, 'h150);
      add_pkt(2, 4, 'h250);
      en = 4'b0110;
      drive();
      acc_until(3, 30, ok);
      ce = 1'b0;
      hold = m_axis_wdata;
      hold_cnt = pkt_cnt;
      nacc = a_src.size();
      nm = m_data.size();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (s_axis_wready !== '0 || m_axis_wvalid !== 1'b0 || m_axis_wdata !== hold) begin
            fails++;
            $display("FAIL ce_freeze%0d wready=%b mvalid=%b data=%h need 0/0/%h",
                     k, s_axis_wready, m_axis_wvalid, m_axis_wdata, hold);
         end
      end
      checks++;
      if (a_src.size() !== nacc || m_data.size() !== nm || pkt_cnt !== hold_cnt) begin
         fails++;
         $display("FAIL ce_no_hs acc=%0d out=%0d cnt=%0d need %0d/%0d/%0d",
                  a_src.size(), m_data.size(), pkt_cnt, nacc, nm, hold_cnt);
      end
      ce = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (m_axis_wdata !== '0 || m_axis_wlast !== 1'b0 || m_axis_src !== '0 || m_axis_wvalid !== 1'b0) begin
         fails++;
         $display("FAIL async_rst_out data=%h last=%b src=%0d valid=%b need 0",
                  m_axis_wdata, m_axis_wlast, m_axis_src, m_axis_wvalid);
      end
      checks++;
      if (pkt_cnt !== 32'd0 || s_axis_wready !== '0) begin
         fails++;
         $display("FAIL async_rst_cnt cnt=%0d wready=%b need 0/0", pkt_cnt, s_axis_wready);
      end
      clear_all();
      add_pkt(0, 1, 'h0c0);
      add_pkt(2, 1, 'h2c0);
      en = 4'b0101;
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_until(2, 20, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL rst_regrant_timeout got %0d flits need 2", m_data.size());
      end else if (m_src[0] !== 0 || m_data[0] !== 'h0c0) begin
         fails++;
         $display("FAIL rst_regrant src=%0d data=%h need 0/0c0", m_src[0], m_data[0]);
      end
   endtask

   task automatic test_random();
      bit ok;
      bit stall;
      logic [W-1:0] pdata;
      int npk, nfl, ptr, s, len;
      int plen [N][$];
      logic [W:0] fl [N][$];
      int e_src[$], e_data[$], e_last[$];
      logic [W:0] f;
      do_reset();
      npk = 40;
      nfl = 0;
      for (int p = 0; p < npk; p++) begin
         s = int'($urandom_range(0, N - 1));
         len = int'($urandom_range(1, 4));
         plen[s].push_back(len);
         for (int j = 0; j < len; j++) begin
            f = {(j == len - 1), W'($urandom)};
            sq[s].push_back(f);
            fl[s].push_back(f);
         end
         nfl += len;
      end
      ptr = 0;
      for (int p = 0; p < npk; p++) begin
         for (int k = 0; k < N; k++) begin
            s = (ptr + k) % N;
            if (plen[s].size() > 0) begin
               len = plen[s].pop_front();
               for (int j = 0; j < len; j++) begin
                  f = fl[s].pop_front();
                  e_src.push_back(s);
                  e_data.push_back(int'(f[W-1:0]));
                  e_last.push_back(int'(f[W]));
               end
               ptr = (s + 1) % N;
               break;
            end
         end
      end
      en = '1;
      drive();
      for (int b = 0; b < 3000 && m_data.size() < nfl; b++) begin
         m_axis_wready = ($urandom_range(0, 3) != 0);
         stall = m_axis_wvalid && !m_axis_wready;
         pdata = m_axis_wdata;
         step();
         if (stall) begin
            checks++;
            if (m_axis_wvalid !== 1'b1 || m_axis_wdata !== pdata) begin
               fails++;
               $display("FAIL rand_stable valid=%b data=%h need 1/%h", m_axis_wvalid, m_axis_wdata, pdata);
            end
         end
      end
      m_axis_wready = 1'b1;
      ok = (m_data.size() == nfl);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL rand_count got %0d flits need %0d", m_data.size(), nfl);
      end else begin
         for (int j = 0; j < nfl; j++) begin
            checks++;
            if (m_src[j] !== e_src[j] || m_data[j] !== e_data[j] || m_last[j] !== e_last[j]) begin
               fails++;
               $display("FAIL rand_flit%0d src=%0d data=%h last=%0d need %0d/%h/%0d",
                        j, m_src[j], m_data[j], m_last[j], e_src[j], e_data[j], e_last[j]);
            end
         end
      end
      checks++;
      if (pkt_cnt !== 32'(npk) || done !== 1'b1) begin
         fails++;
         $display("FAIL rand_pkt_cnt cnt=%0d done=%b need %0d/1", pkt_cnt, done, npk);
      end
   endtask

   initial begin
      s_axis_wdata  = '0;
      s_axis_wvalid = '0;
      s_axis_wlast  = '0;
      m_axis_wready = 1'b1;
      en            = '0;
      test_reset();
      test_single();
      test_rr();
      test_backpressure();
      test_atomicity();
      test_ce_rst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
